// File: rtl/comp_pkg.sv
// Shared definitions for the comparator result filter: relation encoding,
// filter state encoding and the flag-set decoder.
package comp_pkg;

    localparam logic [1:0] REL_EQ  = 2'b00;
    localparam logic [1:0] REL_AEQ = 2'b01;
    localparam logic [1:0] REL_GT  = 2'b10;
    localparam logic [1:0] REL_LT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRACK  = 2'b01,
        STABLE = 2'b10
    } filt_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] cls;
    } decode_t;

    // Priority gt > lt > aeq > eq. A sample with no flag set, or with gt and lt
    // both set, cannot come from a healthy comparator and is marked illegal.
    function automatic decode_t decode_flags(input logic gt, input logic aeq,
                                             input logic eq, input logic lt);
        decode_t d;
        d.legal = (gt | aeq | eq | lt) & ~(gt & lt);
        if (gt)       d.cls = REL_GT;
        else if (lt)  d.cls = REL_LT;
        else if (aeq) d.cls = REL_AEQ;
        else          d.cls = REL_EQ;
        return d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/comp_result_filter.sv
// Debounces the 4-bit comparator relation flags: a relation is published only
// after STABLE_CNT consecutive identical legal samples. Also keeps saturating
// per-class sample counts and a sticky error for illegal flag combinations.
//
// state  | meaning
// IDLE   | no candidate class since reset
// TRACK  | candidate accumulating, run < STABLE_CNT
// STABLE | run reached STABLE_CNT, holding while the class repeats
module comp_result_filter
    import comp_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             aeq,
    input  logic             eq,
    input  logic             lt,
    input  logic             clr_stats,
    output logic [1:0]       rel,
    output logic             rel_valid,
    output logic             rel_chg,
    output logic             err,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_aeq,
    output logic [CNT_W-1:0] cnt_eq
);

    localparam logic [3:0] STABLE_RUN = 4'(STABLE_CNT);

    filt_state_t state, state_nxt;
    logic [1:0]  cand, cand_nxt;
    logic [3:0]  run, run_nxt;
    logic [1:0]  rel_nxt;
    logic        rel_valid_nxt;
    logic        rel_chg_nxt;
    logic        err_nxt;
    logic        sample_ok;
    logic        same_cls;
    logic        commit;
    decode_t     dec;

    // Filter registers: state, candidate, run length, published relation, error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= REL_EQ;
            run       <= 4'd0;
            rel       <= REL_EQ;
            rel_valid <= 1'b0;
            rel_chg   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            run       <= run_nxt;
            rel       <= rel_nxt;
            rel_valid <= rel_valid_nxt;
            rel_chg   <= rel_chg_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state logic: run tracking, commit decision and sticky error.
    always_comb begin
        dec           = decode_flags(gt, aeq, eq, lt);
        sample_ok     = in_valid & dec.legal;
        state_nxt     = state;
        cand_nxt      = cand;
        run_nxt       = run;
        rel_nxt       = rel;
        rel_valid_nxt = rel_valid;
        rel_chg_nxt   = 1'b0;
        commit        = 1'b0;
        same_cls      = 1'b0;

        case (state)
            IDLE:          same_cls = 1'b0;
            TRACK, STABLE: same_cls = (dec.cls == cand);
            default:       same_cls = 1'b0;
        endcase

        if (sample_ok) begin
            if (same_cls) begin
                // Saturated run: holding in STABLE, nothing new to commit.
                if (run != STABLE_RUN) begin
                    run_nxt = run + 4'd1;
                    commit  = (run_nxt == STABLE_RUN);
                end
            end else begin
                cand_nxt = dec.cls;
                run_nxt  = 4'd1;
                commit   = (STABLE_RUN == 4'd1);
            end
            state_nxt = (run_nxt == STABLE_RUN) ? STABLE : TRACK;
            // Re-establishing the relation already published gives no pulse.
            if (commit && (!rel_valid || (cand_nxt != rel))) begin
                rel_nxt       = cand_nxt;
                rel_valid_nxt = 1'b1;
                rel_chg_nxt   = 1'b1;
            end
        end

        if (clr_stats) begin
            err_nxt = 1'b0;
        end else if (in_valid && !dec.legal) begin
            err_nxt = 1'b1;
        end else begin
            err_nxt = err;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_gt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok && (dec.cls == REL_GT)),
        .clr   (clr_stats),
        .count (cnt_gt)
    );

    sat_counter #(.W(CNT_W)) u_cnt_lt (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok && (dec.cls == REL_LT)),
        .clr   (clr_stats),
        .count (cnt_lt)
    );

    sat_counter #(.W(CNT_W)) u_cnt_aeq (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok && (dec.cls == REL_AEQ)),
        .clr   (clr_stats),
        .count (cnt_aeq)
    );

    sat_counter #(.W(CNT_W)) u_cnt_eq (
        .clk   (clk),
        .rst   (rst),
        .inc   (sample_ok && (dec.cls == REL_EQ)),
        .clr   (clr_stats),
        .count (cnt_eq)
    );

endmodule
